// File: rtl/wb_write_queue_pkg.sv
// rtl/wb_write_queue_pkg.sv - shared register-file widths and queue entry type for the writeback queue
package wb_write_queue_pkg;

    localparam int RegNumLog2 = 5;
    localparam int RegAddrBus = RegNumLog2;
    localparam int RegBus     = 32;

    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] ZeroAddr     = '0;

    typedef struct packed {
        logic [RegAddrBus-1:0] addr;
        logic [RegBus-1:0]     data;
    } wbq_entry_t;

    // Register 0 is hardwired; writes to it never reach the register file.
    function automatic logic addr_live(input logic [RegAddrBus-1:0] a);
        return a != ZeroAddr;
    endfunction

endpackage

// File: rtl/wb_write_queue_fifo.sv
// rtl/wb_write_queue_fifo.sv - wbq_fifo: md result storage, pointers, count and per-entry squash bits (WBQ_HAZARD_EN exposes entries)
module wbq_fifo
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wbq_entry_t                 push_entry,
    input  logic                       pop,
    input  logic                       squash_en,
    input  logic [RegAddrBus-1:0]      squash_addr,
    output logic                       head_valid,
    output wbq_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]     count
`ifdef WBQ_HAZARD_EN
    ,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [DEPTH-1:0][RegAddrBus-1:0] entry_addr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    wbq_entry_t [DEPTH-1:0]     mem_q, mem_d;

    // Valid bits double as occupancy-and-not-squashed: cleared on pop, set on push.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        valid_d  = valid_q;
        mem_d    = mem_q;
        if (squash_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].addr == squash_addr) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            mem_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

    assign head_valid = valid_q[rd_ptr_q];
    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

`ifdef WBQ_HAZARD_EN
    always_comb begin
        entry_valid = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem_q[i].addr;
        end
    end
`endif

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - writeback port arbiter: ALU priority, queued mul/div results, squash (WBQ_HAZARD_EN adds read hazard outputs)
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_we,
    input  logic [RegAddrBus-1:0]   alu_waddr,
    input  logic [RegBus-1:0]       alu_wdata,
    input  logic                    md_valid,
    input  logic [RegAddrBus-1:0]   md_waddr,
    input  logic [RegBus-1:0]       md_wdata,
    output logic                    md_ready,
    output logic                    we,
    output logic [RegAddrBus-1:0]   waddr,
    output logic [RegBus-1:0]       wdata,
    output logic [$clog2(DEPTH):0]  q_count
`ifdef WBQ_HAZARD_EN
    ,
    input  logic                    re1,
    input  logic [RegAddrBus-1:0]   raddr1,
    input  logic                    re2,
    input  logic [RegAddrBus-1:0]   raddr2,
    output logic                    hazard1,
    output logic                    hazard2
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   alu_req;
    logic                   md_take;
    logic                   push;
    logic                   pop;
    logic                   head_valid;
    wbq_entry_t             head_entry;
    wbq_entry_t             push_entry;
    logic [CNT_W-1:0]       count;

    logic                   we_q, we_d;
    logic [RegAddrBus-1:0]  waddr_q, waddr_d;
    logic [RegBus-1:0]      wdata_q, wdata_d;

`ifdef WBQ_HAZARD_EN
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][RegAddrBus-1:0] entry_addr;
`endif

    assign alu_req  = (alu_we == WriteEnable) && addr_live(alu_waddr);
    assign md_ready = !rst && (count < CNT_W'(DEPTH));
    assign md_take  = md_valid && md_ready;

    // The ALU write is younger, so an md result to the same register is dead on arrival.
    assign push = md_take && addr_live(md_waddr) && !(alu_req && (alu_waddr == md_waddr));
    assign pop  = !rst && !alu_req && (count != '0);

    assign push_entry = '{addr: md_waddr, data: md_wdata};

    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .squash_en   (alu_req),
        .squash_addr (alu_waddr),
        .head_valid  (head_valid),
        .head_entry  (head_entry),
        .count       (count)
`ifdef WBQ_HAZARD_EN
        ,
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
`endif
    );

    always_comb begin
        we_d    = WriteDisable;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_req) begin
            we_d    = WriteEnable;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end else if (pop && head_valid) begin
            we_d    = WriteEnable;
            waddr_d = head_entry.addr;
            wdata_d = head_entry.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= WriteDisable;
            waddr_q <= ZeroAddr;
            wdata_q <= ZeroWord;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign q_count = count;

`ifdef WBQ_HAZARD_EN
    logic hit1, hit2;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == raddr1)) hit1 = 1'b1;
            if (entry_valid[i] && (entry_addr[i] == raddr2)) hit2 = 1'b1;
        end
        hazard1 = re1 && addr_live(raddr1) && hit1;
        hazard2 = re2 && addr_live(raddr2) && hit2;
    end
`endif

endmodule
